// File: rtl/and_gate.sv
// Bitwise two-input AND with combinational and registered results, per-bit rise
// detection and, when AND_GATE_STATS_EN is defined, a saturating all-ones cycle counter.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             all_q,
    output logic             any_q,
    output logic [WIDTH-1:0] rise
`ifdef AND_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] hi_cnt
`endif
);

    logic [WIDTH-1:0] y_q_reg;
    logic [WIDTH-1:0] y_prev_reg;
    logic             all_q_reg;
    logic             any_q_reg;

    assign y = a & b;

    // Per-bit registered copy and its one-cycle-delayed history for edge detection.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_q_reg[gi]    <= 1'b0;
                    y_prev_reg[gi] <= 1'b0;
                end else begin
                    y_q_reg[gi]    <= a[gi] & b[gi];
                    y_prev_reg[gi] <= y_q_reg[gi];
                end
            end

            assign rise[gi] = y_q_reg[gi] & ~y_prev_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_q_reg <= 1'b0;
            any_q_reg <= 1'b0;
        end else begin
            all_q_reg <= &(a & b);
            any_q_reg <= |(a & b);
        end
    end

    assign y_q   = y_q_reg;
    assign all_q = all_q_reg;
    assign any_q = any_q_reg;

`ifdef AND_GATE_STATS_EN
    logic [CNT_W-1:0] hi_cnt_reg;
    logic [CNT_W-1:0] hi_cnt_next;

    // Counts edges that see all_q high; sticks at all-ones rather than wrapping.
    always_comb begin
        hi_cnt_next = hi_cnt_reg;
        if (all_q_reg && (hi_cnt_reg != {CNT_W{1'b1}})) begin
            hi_cnt_next = hi_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_reg <= '0;
        end else begin
            hi_cnt_reg <= hi_cnt_next;
        end
    end

    assign hi_cnt = hi_cnt_reg;
`else
    // Counter absent; CNT_W is still referenced so an illegal value shows up in the hierarchy.
    if (CNT_W < 2) begin : g_cnt_w_too_small
    end
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed self-checking bench for and_gate: a WIDTH=1 (CNT_W=2) and a WIDTH=4 instance
// share clock and reset; counter checks run only when AND_GATE_STATS_EN is defined.
module tb_and_gate;

    logic       clk;
    logic       rst_n;
    logic       a1, b1;
    logic       y1, y_q1, all_q1, any_q1, rise1;
    logic [3:0] a4, b4;
    logic [3:0] y4, y_q4, rise4;
    logic       all_q4, any_q4;
`ifdef AND_GATE_STATS_EN
    logic [1:0]  hi_cnt1;
    logic [15:0] hi_cnt4;
`endif

    int checks = 0;
    int errors = 0;

    and_gate #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .y     (y1),
        .y_q   (y_q1),
        .all_q (all_q1),
        .any_q (any_q1),
        .rise  (rise1)
`ifdef AND_GATE_STATS_EN
        ,
        .hi_cnt(hi_cnt1)
`endif
    );

    and_gate #(.WIDTH(4), .CNT_W(16)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a4),
        .b     (b4),
        .y     (y4),
        .y_q   (y_q4),
        .all_q (all_q4),
        .any_q (any_q4),
        .rise  (rise4)
`ifdef AND_GATE_STATS_EN
        ,
        .hi_cnt(hi_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        #22;
        checks++;
        if ({y_q1, all_q1, any_q1, rise1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_w1 got %b want 0000", {y_q1, all_q1, any_q1, rise1});
        end
        checks++;
        if ({y_q4, all_q4, any_q4, rise4} !== 10'b0) begin
            errors++;
            $display("FAIL reset_w4 got %b want 0", {y_q4, all_q4, any_q4, rise4});
        end
`ifdef AND_GATE_STATS_EN
        checks++;
        if (hi_cnt1 !== 2'd0 || hi_cnt4 !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", hi_cnt1, hi_cnt4);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs cleared, released");
    endtask

    task automatic test_comb();
        logic [1:0] vec [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        logic       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a1 = vec[i][1];
            b1 = vec[i][0];
            #1;
            checks++;
            if (y1 !== exp[i]) begin
                errors++;
                $display("FAIL comb_y step%0d got %b want %b", i, y1, exp[i]);
            end
            $display("comb: a=%b b=%b y=%b", a1, b1, y1);
            #9;
        end
        a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_registered();
        logic [1:0] vec  [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        logic       expy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       expr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a1 = vec[i][1];
            b1 = vec[i][0];
            @(negedge clk);
            checks++;
            if ({y_q1, all_q1, any_q1} !== {3{expy[i]}}) begin
                errors++;
                $display("FAIL reg_w1 step%0d got yq/all/any=%b want %b", i,
                         {y_q1, all_q1, any_q1}, {3{expy[i]}});
            end
            checks++;
            if (rise1 !== expr[i]) begin
                errors++;
                $display("FAIL rise_w1 step%0d got %b want %b", i, rise1, expr[i]);
            end
            $display("reg: a=%b b=%b y_q=%b rise=%b", a1, b1, y_q1, rise1);
        end
        @(negedge clk);
        checks++;
        if (rise1 !== 1'b0 || y_q1 !== 1'b1) begin
            errors++;
            $display("FAIL rise_w1_clear got rise=%b y_q=%b want 0/1", rise1, y_q1);
        end
        a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wide();
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        checks++;
        if (y4 !== 4'b1000) begin
            errors++;
            $display("FAIL wide_y got %b want 1000", y4);
        end
        @(negedge clk);
        checks++;
        if ({y_q4, any_q4, all_q4, rise4} !== {4'b1000, 1'b1, 1'b0, 4'b1000}) begin
            errors++;
            $display("FAIL wide_partial got yq=%b any=%b all=%b rise=%b want 1000 1 0 1000",
                     y_q4, any_q4, all_q4, rise4);
        end
        $display("wide: a=%b b=%b y_q=%b rise=%b", a4, b4, y_q4, rise4);
        a4 = 4'hF; b4 = 4'hF;
        @(negedge clk);
        checks++;
        if ({y_q4, all_q4, any_q4, rise4} !== {4'b1111, 1'b1, 1'b1, 4'b0111}) begin
            errors++;
            $display("FAIL wide_full got yq=%b all=%b any=%b rise=%b want 1111 1 1 0111",
                     y_q4, all_q4, any_q4, rise4);
        end
        $display("wide: a=%b b=%b y_q=%b rise=%b", a4, b4, y_q4, rise4);
        @(negedge clk);
        checks++;
        if (rise4 !== 4'b0000) begin
            errors++;
            $display("FAIL wide_rise_clear got %b want 0000", rise4);
        end
    endtask

    task automatic test_async_reset();
        a1 = 1'b1; b1 = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y_q1, all_q1, any_q1, rise1} !== 4'b0000 || y1 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got regs=%b y=%b want 0000 1",
                     {y_q1, all_q1, any_q1, rise1}, y1);
        end
        checks++;
        if ({y_q4, all_q4, rise4} !== 9'b0 || y4 !== 4'hF) begin
            errors++;
            $display("FAIL async_reset_w4 got yq=%b all=%b rise=%b y=%b", y_q4, all_q4, rise4, y4);
        end
`ifdef AND_GATE_STATS_EN
        checks++;
        if (hi_cnt1 !== 2'd0 || hi_cnt4 !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_cnt got %0d/%0d want 0/0", hi_cnt1, hi_cnt4);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (y_q1 !== 1'b1 || rise1 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got y_q=%b rise=%b want 1/1", y_q1, rise1);
        end
        $display("async reset: y_q=%b rise=%b after release", y_q1, rise1);
        @(negedge clk);
        checks++;
        if (rise1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rise_clear got %b want 0", rise1);
        end
    endtask

`ifdef AND_GATE_STATS_EN
    task automatic test_counter();
        logic [1:0] exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        a1 = 1'b0; b1 = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (hi_cnt1 !== exp[i]) begin
                errors++;
                $display("FAIL hi_cnt cycle%0d got %0d want %0d", i, hi_cnt1, exp[i]);
            end
            $display("counter: cycle %0d hi_cnt=%0d", i, hi_cnt1);
        end
        a1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (hi_cnt1 !== 2'd3) begin
            errors++;
            $display("FAIL hi_cnt_hold got %0d want 3", hi_cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_comb();
        test_registered();
        test_wide();
        test_async_reset();
`ifdef AND_GATE_STATS_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_gate.md
# and_gate

Parameterised bitwise two-input AND with a combinational result, a registered copy, edge detection and an optional saturating activity counter. Used as a leaf logic cell wherever a gated enable or mask is needed. The combinational path serves glue logic; the registered outputs serve timing-closed consumers and status logic.

## Interface
- WIDTH, 1, bit width of operands and results (≥1)
- CNT_W, 16, width of the activity counter (≥2)

- clk  in  1  rising-edge clock for all registered outputs
- rst_n  in  1  asynchronous active-low reset; clears every register immediately
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- y  out  WIDTH  combinational a & b
- y_q  out  WIDTH  registered y
- all_q  out  1  registered &y (every bit set)
- any_q  out  1  registered |y (at least one bit set)
- rise  out  WIDTH  one-cycle pulse per bit where y_q goes 0→1
- hi_cnt  out  CNT_W  cycles with all_q=1, saturating (AND_GATE_STATS_EN only)

## Operation
- y = a & b bitwise, purely combinational; independent of clk and rst_n.
- Each rising clk: y_q ← a & b; all_q ← &(a & b); any_q ← |(a & b).
- rise = y_q & ~y_prev, where y_prev is y_q delayed one cycle; registered-domain output, combinational from flops only.
- hi_cnt increments by 1 on each clk edge where all_q is 1 at that edge; holds at 2^CNT_W−1 once reached (no wrap).
- X on a or b propagates per standard AND semantics (0 & X = 0); no X suppression.
- No handshake; inputs sampled every cycle.

## Timing
- y: zero-cycle latency, follows inputs within the same delta.
- y_q, all_q, any_q: 1-cycle latency from input change to output.
- rise: asserted in the cycle y_q first shows 1, deasserted next cycle.
- hi_cnt: reflects all_q with 1 further cycle of latency (2 cycles from inputs).
- Reset: on rst_n falling, y_q, all_q, any_q, rise, y_prev, hi_cnt go to 0 without waiting for clk; y unaffected.
- Reset mid-operation: registered state lost; first edge after rst_n rises loads fresh values; a 0→1 transition relative to the reset value of 0 produces a rise pulse.
- rst_n deassertion must be synchronous to clk (provided by the system reset controller); no internal synchroniser.

## Configuration
- AND_GATE_STATS_EN defined: hi_cnt port and counter logic present as above.
- Undefined: hi_cnt port absent, no counter flops; all other behaviour identical.

## Test plan
- WIDTH=1, rst_n=1, apply (a,b)=(1,1),(0,1),(1,0),(1,1) 10 ns apart -> y=1,0,0,1 immediately at each step, independent of clk.
- Same sequence with clk running -> y_q, all_q, any_q equal 1,0,0,1 one cycle after each change; rise pulses for one cycle after the first and last steps.
- WIDTH=4, a=4'b1100, b=4'b1010 -> y=4'b1000, next edge y_q=4'b1000, any_q=1, all_q=0; then a=b=4'hF -> all_q=1, rise=4'b0111 for one cycle.
- Drive rst_n low asynchronously mid-clock-period with a=b=1 -> y_q, all_q, any_q, rise, hi_cnt read 0 before next edge; y stays 1; after release, y_q=1 at first edge, rise=1 for one cycle.
- AND_GATE_STATS_EN, CNT_W=2, a=b=1 held for 6 cycles -> hi_cnt counts 1,2,3 then holds at 3; a=0 -> hi_cnt holds 3.
- AND_GATE_STATS_EN undefined -> design elaborates without hi_cnt; other outputs match the previous scenarios.
